// File: rtl/opb_pkg.sv
// Shared definitions for the OPB master arbiter: FSM state encoding, sizing
// constants and the round-robin pointer wrap helper.
package opb_pkg;

    localparam int OPB_MAX_MASTERS = 8;
    localparam int IDX_W           = 3;
    localparam int GRANT_WAIT      = 4;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_BUSY  = 2'd2
    } arb_state_t;

    // Next index after v in a ring of n masters.
    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v, input int n);
        if (v == IDX_W'(n - 1)) begin
            return '0;
        end
        return v + IDX_W'(1);
    endfunction

endpackage

// File: rtl/opb_master_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first requester at or after ptr,
// returned both one-hot and as an index.
module rr_pick
    import opb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    localparam int PW = IDX_W + 1;

    logic [2*N-1:0] req2;
    logic [N-1:0]   rotated;
    logic [PW-1:0]  pos;

    // Doubling the request vector lets a plain right shift do the rotation.
    always_comb begin
        req2    = {req, req};
        rotated = N'(req2 >> ptr);
        onehot  = '0;
        idx     = '0;
        found   = 1'b0;
        pos     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && rotated[i]) begin
                found = 1'b1;
                pos   = {1'b0, ptr} + PW'(i);
                if (pos >= PW'(N)) begin
                    pos = pos - PW'(N);
                end
                idx    = pos[IDX_W-1:0];
                onehot = N'(1) << pos;
            end
        end
    end

endmodule

// File: rtl/opb_master_arbiter.sv
// Round-robin OPB master arbiter with bus-lock limit, select forwarding and
// slave-timeout generation.
module opb_master_arbiter
    import opb_pkg::*;
#(
    parameter int N_MASTERS   = 4,
    parameter int TIMEOUT_CYC = 16,
    parameter int LOCK_LIMIT  = 8
) (
    input  logic                 opb_clk,
    input  logic                 opb_rst_n,
    input  logic [N_MASTERS-1:0] m_request,
    input  logic [N_MASTERS-1:0] m_buslock,
    input  logic [N_MASTERS-1:0] m_select,
    input  logic                 opb_xferack,
    input  logic                 opb_errack,
    input  logic                 opb_retry,
    output logic [N_MASTERS-1:0] opb_mgrant,
    output logic                 opb_select,
    output logic                 opb_timeout,
    output logic [2:0]           owner_id,
    output logic                 grant_vld
);

    localparam logic [15:0] TO_TERM   = 16'(TIMEOUT_CYC - 1);
    localparam logic [31:0] LOCK_MAX  = 32'((LOCK_LIMIT > 0) ? LOCK_LIMIT - 1 : 0);
    localparam logic [2:0]  WAIT_TERM = 3'(GRANT_WAIT - 1);

    arb_state_t             state;
    logic [N_MASTERS-1:0]   mgrant;
    logic [IDX_W-1:0]       owner;
    logic [IDX_W-1:0]       rr_ptr;
    logic [31:0]            lock_cnt;
    logic [2:0]             wait_cnt;
    logic [15:0]            to_cnt;
    logic                   timeout_q;

    logic [N_MASTERS-1:0]   pick_onehot;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_found;

    logic                   any_ack;
    logic                   own_sel;
    logic                   own_req;
    logic                   own_lock;
    logic                   lock_ok;
    logic                   done;

    rr_pick #(.N(N_MASTERS)) u_pick (
        .req    (m_request),
        .ptr    (rr_ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .found  (pick_found)
    );

    assign opb_select  = |(m_select & mgrant);
    assign opb_mgrant  = mgrant;
    assign grant_vld   = |mgrant;
    assign owner_id    = owner;
    assign opb_timeout = timeout_q;

    assign any_ack  = opb_xferack | opb_errack | opb_retry;
    assign own_sel  = |(m_select & mgrant);
    assign own_req  = |(m_request & mgrant);
    assign own_lock = |(m_buslock & mgrant);
    // lock_cnt counts re-grants, so LOCK_LIMIT bounds total back-to-back transfers.
    assign lock_ok  = own_lock && ((LOCK_LIMIT == 0) || (lock_cnt < LOCK_MAX));
    // A transfer acked in the very cycle select first rises still ends cleanly.
    assign done     = (any_ack | timeout_q) &&
                      ((state == ARB_BUSY) || ((state == ARB_GRANT) && own_sel));

    always_ff @(posedge opb_clk) begin
        if (!opb_rst_n) begin
            to_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            if (!opb_select || any_ack) begin
                to_cnt <= '0;
            end else if (to_cnt == TO_TERM) begin
                to_cnt    <= '0;
                timeout_q <= 1'b1;
            end else begin
                to_cnt <= to_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge opb_clk) begin
        if (!opb_rst_n) begin
            state    <= ARB_IDLE;
            mgrant   <= '0;
            owner    <= '0;
            rr_ptr   <= '0;
            lock_cnt <= '0;
            wait_cnt <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_found) begin
                        mgrant   <= pick_onehot;
                        owner    <= pick_idx;
                        wait_cnt <= '0;
                        state    <= ARB_GRANT;
                    end
                end
                ARB_GRANT, ARB_BUSY: begin
                    if (done) begin
                        if (lock_ok) begin
                            lock_cnt <= lock_cnt + 32'd1;
                            wait_cnt <= '0;
                            state    <= ARB_GRANT;
                        end else begin
                            mgrant   <= '0;
                            rr_ptr   <= wrap_inc(owner, N_MASTERS);
                            lock_cnt <= '0;
                            state    <= ARB_IDLE;
                        end
                    end else if (state == ARB_GRANT) begin
                        if (own_sel) begin
                            state <= ARB_BUSY;
                        end else if (!own_req || (wait_cnt == WAIT_TERM)) begin
                            // Advance past the abandoned owner so the next requester is served.
                            mgrant   <= '0;
                            rr_ptr   <= wrap_inc(owner, N_MASTERS);
                            lock_cnt <= '0;
                            state    <= ARB_IDLE;
                        end else begin
                            wait_cnt <= wait_cnt + 3'd1;
                        end
                    end
                end
                default: begin
                    mgrant <= '0;
                    state  <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule
